// File: rtl/ucode_stk_arb_if.sv
// Stack-cache port bundle shared by the IU pipeline, the ucode sequencer and the
// arbiter. The requesters and the stack cache sit on the master side; the
// arbiter uses the slave side.
interface ucode_stk_arb_if;
  logic pipe_req;
  logic pipe_wr;
  logic u_f01_wt_stk;
  logic u_f02_rd_stk;
  logic u_done;
  logic u_abt_cur;
  logic u_abt_rdwt;
  logic ie_kill_ucode;
  logic sc_ack;
  logic gnt_pipe;
  logic gnt_ucode;
  logic port_wr;
  logic sc_abort;
  logic pipe_stall;
  logic ucode_stall;

  modport master (
    output pipe_req, pipe_wr, u_f01_wt_stk, u_f02_rd_stk, u_done,
           u_abt_cur, u_abt_rdwt, ie_kill_ucode, sc_ack,
    input  gnt_pipe, gnt_ucode, port_wr, sc_abort, pipe_stall, ucode_stall
  );

  modport slave (
    input  pipe_req, pipe_wr, u_f01_wt_stk, u_f02_rd_stk, u_done,
           u_abt_cur, u_abt_rdwt, ie_kill_ucode, sc_ack,
    output gnt_pipe, gnt_ucode, port_wr, sc_abort, pipe_stall, ucode_stall
  );
endinterface

// File: rtl/ucode_stk_arb.sv
// Arbiter for the single stack-cache access port shared by the IU pipeline and
// the ucode sequencer. One access outstanding at a time; ucode aborts/kills
// cancel a ucode access in flight; a starvation counter bounds how many
// consecutive ucode grants can be taken while the pipeline waits.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | port free, arbitrate every cycle
// PIPE_BUSY | pipeline owns the port, waiting for sc_ack
// UC_BUSY   | ucode owns the port, waiting for sc_ack (abort/kill cancels)
// ABORT     | one-cycle sc_abort to the stack cache, then back to IDLE
module ucode_stk_arb #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input logic            clk,
  input logic            reset_l,
  ucode_stk_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PIPE_BUSY = 2'd1,
    UC_BUSY   = 2'd2,
    ABORT     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_pipe_q;
  logic             gnt_ucode_q;
  logic             port_wr_q;
  logic             sc_abort_q;

  logic u_req;
  logic busy_ack;
  logic arb_en;
  logic starve_ok;
  logic win_uc;
  logic win_pipe;
  logic uc_cancel;
  logic cnt_clr;

  // Request qualification, arbitration decision and cancel detection.
  always_comb begin
    u_req     = (bus.u_f01_wt_stk | bus.u_f02_rd_stk) & ~bus.u_abt_rdwt & ~bus.ie_kill_ucode;
    busy_ack  = ((state == PIPE_BUSY) | (state == UC_BUSY)) & bus.sc_ack;
    arb_en    = (state == IDLE) | busy_ack;
    starve_ok = (cnt < STARVE_LIM);
    win_uc    = arb_en & u_req & (~bus.pipe_req | starve_ok);
    win_pipe  = arb_en & ~win_uc & bus.pipe_req;
    // An ack in the same cycle as an abort/kill completes the access instead.
    uc_cancel = (state == UC_BUSY) & (bus.u_abt_cur | bus.ie_kill_ucode) & ~bus.sc_ack;
    cnt_clr   = ~bus.pipe_req | bus.u_done | bus.ie_kill_ucode | win_pipe;
  end

  // Port ownership FSM with registered grant, write qualifier and abort strobe.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      gnt_pipe_q  <= 1'b0;
      gnt_ucode_q <= 1'b0;
      port_wr_q   <= 1'b0;
      sc_abort_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, PIPE_BUSY, UC_BUSY: begin
          if (uc_cancel) begin
            state       <= ABORT;
            gnt_pipe_q  <= 1'b0;
            gnt_ucode_q <= 1'b0;
            port_wr_q   <= 1'b0;
            sc_abort_q  <= 1'b1;
          end else if (win_uc) begin
            state       <= UC_BUSY;
            gnt_pipe_q  <= 1'b0;
            gnt_ucode_q <= 1'b1;
            // Both ucode bits set is treated as a write.
            port_wr_q   <= bus.u_f01_wt_stk;
            sc_abort_q  <= 1'b0;
          end else if (win_pipe) begin
            state       <= PIPE_BUSY;
            gnt_pipe_q  <= 1'b1;
            gnt_ucode_q <= 1'b0;
            port_wr_q   <= bus.pipe_wr;
            sc_abort_q  <= 1'b0;
          end else if (arb_en) begin
            state       <= IDLE;
            gnt_pipe_q  <= 1'b0;
            gnt_ucode_q <= 1'b0;
            port_wr_q   <= 1'b0;
            sc_abort_q  <= 1'b0;
          end
        end
        ABORT: begin
          state       <= IDLE;
          gnt_pipe_q  <= 1'b0;
          gnt_ucode_q <= 1'b0;
          port_wr_q   <= 1'b0;
          sc_abort_q  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          gnt_pipe_q  <= 1'b0;
          gnt_ucode_q <= 1'b0;
          port_wr_q   <= 1'b0;
          sc_abort_q  <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: consecutive ucode grants taken while the pipeline waits.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (win_uc && (cnt < STARVE_LIM)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered grants out; stalls are combinational so they drop in the ack cycle.
  always_comb begin
    bus.gnt_pipe    = gnt_pipe_q;
    bus.gnt_ucode   = gnt_ucode_q;
    bus.port_wr     = port_wr_q;
    bus.sc_abort    = sc_abort_q;
    bus.pipe_stall  = bus.pipe_req & ~(gnt_pipe_q & bus.sc_ack);
    bus.ucode_stall = u_req & ~(gnt_ucode_q & bus.sc_ack);
  end

endmodule
